// File: rtl/mem_perf_monitor.sv
// Performance monitor for the CPU-side mem_system handshake.
// Counts traffic, checks latency windows and keeps a latency histogram.
module mem_perf_monitor #(
  parameter int CNT_W        = 32,
  parameter int LAT_W        = 8,
  parameter int HIT_MAX_LAT  = 2,
  parameter int MISS_MIN_LAT = 3,
  parameter int MISS_MAX_LAT = 20,
  parameter int TIMEOUT      = 64,
  parameter int NBINS        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     Rd,
  input  logic                     Wr,
  input  logic                     Done,
  input  logic                     Stall,
  input  logic                     CacheHit,
  input  logic [$clog2(NBINS)-1:0] bin_sel,
  output logic [CNT_W-1:0]         bin_count,
  output logic [CNT_W-1:0]         n_requests,
  output logic [CNT_W-1:0]         n_replies,
  output logic [CNT_W-1:0]         n_hits,
  output logic [CNT_W-1:0]         n_reads,
  output logic [CNT_W-1:0]         n_writes,
  output logic [CNT_W-1:0]         n_perf_err,
  output logic [CNT_W-1:0]         n_timeouts,
  output logic [CNT_W-1:0]         n_aborts,
  output logic [CNT_W-1:0]         n_spurious,
  output logic [LAT_W-1:0]         lat_last,
  output logic [LAT_W-1:0]         lat_max,
  output logic                     busy,
  output logic                     err
);

  localparam int BW = $clog2(NBINS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] req_q, req_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] ab_q, ab_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] bins_q [NBINS];
  logic [CNT_W-1:0] bins_d [NBINS];
  logic             err_q, err_d;

  logic             req, start, cmpl, fail;
  logic [LAT_W-1:0] lat_inc, lat_l;
  logic [BW-1:0]    hidx;
  logic [1:0]       perf_inc;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] v,
    input logic [1:0]       n
  );
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign req     = (Rd | Wr) & ~Stall;
  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    last_d  = last_q;
    max_d   = max_q;
    req_d   = req_q;
    rep_d   = rep_q;
    hit_d   = hit_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    perf_d  = perf_q;
    to_d    = to_q;
    ab_d    = ab_q;
    sp_d    = sp_q;
    bins_d  = bins_q;
    start   = 1'b0;
    cmpl    = 1'b0;
    fail    = 1'b0;
    lat_l   = '0;
    hidx    = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          start = 1'b1;
          if (Done) begin
            cmpl  = 1'b1;
            lat_l = LAT_W'(1);
          end else begin
            state_d = WAIT;
            lat_d   = LAT_W'(1);
          end
        end else if (Done) begin
          sp_d = sat_add(sp_q, 2'd1);
        end
      end
      WAIT: begin
        if (Done) begin
          cmpl    = 1'b1;
          lat_l   = lat_inc;
          state_d = IDLE;
          lat_d   = '0;
        end else if (!(Rd | Wr)) begin
          ab_d    = sat_add(ab_q, 2'd1);
          state_d = IDLE;
          lat_d   = '0;
        end else if (32'(lat_q) + 1 == TIMEOUT) begin
          to_d    = sat_add(to_q, 2'd1);
          state_d = IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      req_d = sat_add(req_q, 2'd1);
      if (Rd) rd_d = sat_add(rd_q, 2'd1);
      else    wr_d = sat_add(wr_q, 2'd1);
    end

    if (cmpl) begin
      rep_d = sat_add(rep_q, 2'd1);
      if (CacheHit) begin
        hit_d = sat_add(hit_q, 2'd1);
        fail  = 32'(lat_l) > HIT_MAX_LAT;
      end else begin
        fail = (32'(lat_l) < MISS_MIN_LAT) ||
               (32'(lat_l) > MISS_MAX_LAT);
      end
      last_d = lat_l;
      if (lat_l > max_q) max_d = lat_l;
      // Latencies of NBINS and above pile into the last bin
      if (32'(lat_l) >= NBINS) hidx = BW'(NBINS - 1);
      else                     hidx = BW'(lat_l - LAT_W'(1));
      bins_d[hidx] = sat_add(bins_q[hidx], 2'd1);
    end

    perf_inc = {1'b0, start & Rd & Wr} + {1'b0, fail};
    perf_d   = sat_add(perf_q, perf_inc);

    if (clr) begin
      state_d = IDLE;
      lat_d   = '0;
      last_d  = '0;
      max_d   = '0;
      req_d   = '0;
      rep_d   = '0;
      hit_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      perf_d  = '0;
      to_d    = '0;
      ab_d    = '0;
      sp_d    = '0;
      for (int i = 0; i < NBINS; i++) bins_d[i] = '0;
    end

    err_d = (|perf_d) | (|to_d) | (|ab_d) | (|sp_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      req_q   <= '0;
      rep_q   <= '0;
      hit_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      perf_q  <= '0;
      to_q    <= '0;
      ab_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      max_q   <= max_d;
      req_q   <= req_d;
      rep_q   <= rep_d;
      hit_q   <= hit_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      perf_q  <= perf_d;
      to_q    <= to_d;
      ab_q    <= ab_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= bins_d[i];
    end
  end

  always_comb begin
    bin_count = '0;
    if (32'(bin_sel) < NBINS) bin_count = bins_q[bin_sel];
  end

  assign n_requests = req_q;
  assign n_replies  = rep_q;
  assign n_hits     = hit_q;
  assign n_reads    = rd_q;
  assign n_writes   = wr_q;
  assign n_perf_err = perf_q;
  assign n_timeouts = to_q;
  assign n_aborts   = ab_q;
  assign n_spurious = sp_q;
  assign lat_last   = last_q;
  assign lat_max    = max_q;
  assign busy       = (state_q == WAIT);
  assign err        = err_q;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Scoreboard bench for mem_perf_monitor (CNT_W=4 to reach saturation).
// Expectations are queued with the stimulus and drained after it.
module tb_mem_perf_monitor;

  localparam int CW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          Rd = 1'b0, Wr = 1'b0, Done = 1'b0;
  logic          Stall = 1'b0, CacheHit = 1'b0;
  logic [2:0]    bin_sel = '0;
  logic [CW-1:0] bin_count;
  logic [CW-1:0] n_requests, n_replies, n_hits, n_reads, n_writes;
  logic [CW-1:0] n_perf_err, n_timeouts, n_aborts, n_spurious;
  logic [LW-1:0] lat_last, lat_max;
  logic          busy, err;

  mem_perf_monitor #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .Rd(Rd), .Wr(Wr), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .bin_sel(bin_sel),
    .bin_count(bin_count),
    .n_requests(n_requests), .n_replies(n_replies),
    .n_hits(n_hits), .n_reads(n_reads), .n_writes(n_writes),
    .n_perf_err(n_perf_err), .n_timeouts(n_timeouts),
    .n_aborts(n_aborts), .n_spurious(n_spurious),
    .lat_last(lat_last), .lat_max(lat_max),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  localparam int S_REQ = 0, S_REP = 1, S_HIT = 2, S_RD = 3;
  localparam int S_WR = 4, S_PERF = 5, S_TO = 6, S_AB = 7;
  localparam int S_SP = 8, S_LAST = 9, S_MAX = 10;
  localparam int S_BUSY = 11, S_ERR = 12, S_BIN = 13;

  typedef struct {
    string tag;
    int    s;
    int    idx;
    int    v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int get(input int s);
    case (s)
      S_REQ:   return int'(n_requests);
      S_REP:   return int'(n_replies);
      S_HIT:   return int'(n_hits);
      S_RD:    return int'(n_reads);
      S_WR:    return int'(n_writes);
      S_PERF:  return int'(n_perf_err);
      S_TO:    return int'(n_timeouts);
      S_AB:    return int'(n_aborts);
      S_SP:    return int'(n_spurious);
      S_LAST:  return int'(lat_last);
      S_MAX:   return int'(lat_max);
      S_BUSY:  return int'(busy);
      S_ERR:   return int'(err);
      default: return int'(bin_count);
    endcase
  endfunction

  task automatic ex(input string tag, input int s,
                    input int v, input int idx = 0);
    exp_t e;
    e.tag = tag; e.s = s; e.v = v; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.s == S_BIN) begin
        bin_sel = 3'(e.idx);
        #1;
      end
      chk(e.tag, get(e.s), e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic idle_in();
    Rd = 1'b0; Wr = 1'b0; Done = 1'b0;
    CacheHit = 1'b0; Stall = 1'b0;
  endtask

  // One request completing with latency l
  task automatic do_req(input logic rd, input logic wr,
                        input int l, input logic hit);
    Rd = rd; Wr = wr;
    if (l > 1) begin
      step();
      repeat (l - 2) step();
    end
    Done = 1'b1; CacheHit = hit;
    step();
    idle_in();
    step();
  endtask

  task automatic ex_zero(input string p);
    ex({p, "_req"}, S_REQ, 0);
    ex({p, "_rep"}, S_REP, 0);
    ex({p, "_hit"}, S_HIT, 0);
    ex({p, "_rd"}, S_RD, 0);
    ex({p, "_perf"}, S_PERF, 0);
    ex({p, "_last"}, S_LAST, 0);
    ex({p, "_max"}, S_MAX, 0);
    ex({p, "_busy"}, S_BUSY, 0);
    ex({p, "_err"}, S_ERR, 0);
  endtask

  initial begin
    int n;
    ex_zero("rst");
    ex("rst_bin0", S_BIN, 0, 0);
    repeat (2) step();
    drain();
    rst = 1'b1;
    step();

    // read hit, Done one cycle after request
    ex("h_req", S_REQ, 1); ex("h_rep", S_REP, 1);
    ex("h_hit", S_HIT, 1); ex("h_rd", S_RD, 1);
    ex("h_last", S_LAST, 2); ex("h_perf", S_PERF, 0);
    ex("h_bin1", S_BIN, 1, 1); ex("h_busy", S_BUSY, 0);
    do_req(1'b1, 1'b0, 2, 1'b1);
    drain();

    // write miss at latency 10
    do_clr();
    ex("w_wr", S_WR, 1); ex("w_rd", S_RD, 0);
    ex("w_last", S_LAST, 10); ex("w_max", S_MAX, 10);
    ex("w_perf", S_PERF, 0); ex("w_bin7", S_BIN, 1, 7);
    ex("w_bin1", S_BIN, 0, 1);
    do_req(1'b0, 1'b1, 10, 1'b0);
    drain();

    // slow hit then fast miss, then clr
    do_clr();
    ex("pe_perf", S_PERF, 2); ex("pe_err", S_ERR, 1);
    ex("pe_max", S_MAX, 4); ex("pe_last", S_LAST, 2);
    ex("pe_bin3", S_BIN, 1, 3);
    do_req(1'b1, 1'b0, 4, 1'b1);
    do_req(1'b1, 1'b0, 2, 1'b0);
    drain();
    ex_zero("clr");
    ex("clr_bin3", S_BIN, 0, 3);
    do_clr();
    drain();

    // timeout: busy must last exactly 63 cycles after start
    Rd = 1'b1;
    step();
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    Rd = 1'b0;
    chk("to_cycles", n, 63);
    ex("to_cnt", S_TO, 1); ex("to_busy", S_BUSY, 0);
    ex("to_rep", S_REP, 0); ex("to_err", S_ERR, 1);
    drain();
    ex("to_req2", S_REQ, 2); ex("to_rep2", S_REP, 1);
    ex("to_last2", S_LAST, 3); ex("to_perf2", S_PERF, 0);
    do_req(1'b1, 1'b0, 3, 1'b0);
    drain();

    // spurious Done, including a stalled request in IDLE
    do_clr();
    ex("sp_cnt", S_SP, 1); ex("sp_req", S_REQ, 0);
    ex("sp_rep", S_REP, 0); ex("sp_err", S_ERR, 1);
    Rd = 1'b1; Stall = 1'b1; Done = 1'b1;
    step();
    idle_in();
    step();
    drain();

    // Rd and Wr together: counted as read plus a perf error
    do_clr();
    ex("rw_rd", S_RD, 1); ex("rw_wr", S_WR, 0);
    ex("rw_perf", S_PERF, 1); ex("rw_err", S_ERR, 1);
    do_req(1'b1, 1'b1, 3, 1'b0);
    drain();

    // abort mid-WAIT, with Stall held during the wait
    do_clr();
    ex("ab_cnt", S_AB, 1); ex("ab_rep", S_REP, 0);
    ex("ab_req", S_REQ, 1); ex("ab_busy", S_BUSY, 0);
    Rd = 1'b1;
    step();
    Stall = 1'b1;
    repeat (3) step();
    Rd = 1'b0;
    step();
    idle_in();
    drain();

    // async reset at latency 5
    do_clr();
    Rd = 1'b1;
    step();
    repeat (4) step();
    ex("ar_pre_busy", S_BUSY, 1); ex("ar_pre_req", S_REQ, 1);
    drain();
    #1 rst = 1'b0;
    #1;
    ex("ar_busy", S_BUSY, 0); ex("ar_req", S_REQ, 0);
    ex("ar_rd", S_RD, 0);
    drain();
    Rd = 1'b0;
    #1 rst = 1'b1;
    step();
    ex("ar_last", S_LAST, 1); ex("ar_req2", S_REQ, 1);
    ex("ar_bin0", S_BIN, 1, 0);
    do_req(1'b1, 1'b0, 1, 1'b1);
    drain();

    // 20 back-to-back latency-1 hits saturate 4-bit counters
    do_clr();
    ex("sat_hit", S_HIT, 15); ex("sat_req", S_REQ, 15);
    ex("sat_rep", S_REP, 15); ex("sat_rd", S_RD, 15);
    ex("sat_bin0", S_BIN, 15, 0); ex("sat_perf", S_PERF, 0);
    Rd = 1'b1; Done = 1'b1; CacheHit = 1'b1;
    repeat (20) step();
    idle_in();
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
